vlg_echo_dist: RTL and testbench
================================

Name: vlg_echo_dist

Overview:
- Downstream consumer of the echo pulse-width measurement stage.
- Takes each new echo high-time sample `t` (in microseconds) and range-checks it against the sensor's 2 mm to 4500 mm window (11 to 26011 us).
- Converts valid samples to millimetres using s ≈ 0.173·t, implemented as a sequential shift-add multiply by 177 followed by a right shift of 10.
- Smooths the result with a 4-deep moving average and presents distance plus an error flag to the display/UART logic.

Parameters:
- T_MIN, 11, smallest legal echo time in us (inclusive).
- T_MAX, 26011, largest legal echo time in us (inclusive).
- COEF, 177, multiplier constant, 8 bits wide; 177/1024 = 0.17285 mm/us.
- SHIFT, 10, right shift applied after the multiply.
- AVG_LOG2, 2, log2 of the averaging depth (fixed at 4 entries).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_t_vld  in  1  one-cycle strobe: new sample present on i_t_us (wired from the echo falling-edge pulse, delayed one cycle).
- i_t_us  in  16  echo high time in us.
- o_busy  out  1  high while a sample is being processed.
- o_dist_vld  out  1  one-cycle strobe: o_dist_mm / o_range_err updated.
- o_dist_mm  out  16  averaged distance in mm.
- o_dist_raw  out  16  unaveraged distance of the last in-range sample.
- o_range_err  out  1  high when the last accepted sample was out of range.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - Asserting i_rst clears every register immediately: all outputs 0, FSM to IDLE, ring entries 0, fill flag cleared.
  - This applies mid-operation as well; an in-flight sample is discarded with no o_dist_vld.
- FSM states: IDLE, CHECK, MUL, AVG, OUT. Cycle N is the cycle in which IDLE sees i_t_vld=1.
- IDLE
  - o_busy=0.
  - On i_t_vld: latch i_t_us into t_reg, go to CHECK.
  - o_busy=1 from N+1 until return to IDLE.
- CHECK (N+1)
  - If t_reg < T_MIN or t_reg > T_MAX: go to OUT with err=1. Ring, o_dist_mm and o_dist_raw are unchanged.
  - Otherwise: clear the 24-bit accumulator, load multiplier bit index 0, go to MUL.
- MUL (N+2..N+9, exactly 8 cycles)
  - Each cycle, if COEF bit k is set, accumulator += t_reg << k; then k increments.
  - After k=7, go to AVG.
  - Max product is 26011·177 = 4,603,947, which fits in 23 bits; no overflow is possible.
- AVG (N+10)
  - raw = accumulator >> SHIFT (truncate, no rounding); raw ≤ 4496.
  - If the fill flag is 0 (first in-range sample since reset): write raw into all 4 ring entries and set the fill flag.
  - Otherwise: overwrite the oldest entry via a 2-bit wrap-around write pointer.
  - Sum = 18-bit sum of the 4 entries after the write; avg = sum >> 2 (truncate).
  - Go to OUT.
- OUT (N+11 for in-range samples, N+2 for errors)
  - o_dist_vld=1 for one cycle.
  - Same edge updates o_range_err=err; for in-range samples also o_dist_raw=raw and o_dist_mm=avg.
  - Return to IDLE; o_busy=0 from the next cycle.
- Overlapping input: i_t_vld asserted while o_busy=1 is ignored (sample dropped, no queueing).
  - i_t_vld in the same cycle the FSM returns to IDLE (the IDLE cycle itself) is accepted.
- Outputs other than o_dist_vld hold their values between updates.

Test Plan:
1. Reset, then i_t_vld with t=5780 → o_dist_vld exactly 11 cycles later; o_dist_raw=999, o_dist_mm=999 (ring preloaded), o_range_err=0.
2. After (1), t=2890 → o_dist_raw=499, o_dist_mm=(3·999+499)>>2=874. Then three more samples of t=2890 → o_dist_mm converges to 499.
3. Boundaries:
   - t=11 → raw 1, err 0.
   - t=26011 → raw 4496, err 0.
   - t=10 → o_dist_vld 2 cycles after strobe, err=1, o_dist_mm unchanged.
   - t=26012 and t=0 → err=1, o_dist_mm unchanged.
4. Issue a second i_t_vld at cycles N+3 and N+11 → both dropped, single o_dist_vld; strobe at the following IDLE cycle is accepted.
5. Assert i_rst asynchronously during MUL (cycle N+5) → all outputs 0 immediately, no o_dist_vld. Next sample t=5780 gets preload behaviour (o_dist_mm=999).
6. Ring wrap: feed 6 in-range samples t=1157 (raw 199) then t=5780 → verify the pointer wraps after entry 3 and o_dist_mm equals the sum of the last 4 raw values >> 2.

Source files
------------

// File: rtl/vlg_echo_dist.sv
// Echo-time to distance converter.
// Takes one echo high-time sample (us) and range-checks it.
// In-range samples are converted to mm with a shift-add multiply by COEF
// and a right shift by SHIFT.
// The result is then smoothed with a 4-entry moving average.
module vlg_echo_dist #(
    parameter int T_MIN    = 11,
    parameter int T_MAX    = 26011,
    parameter int COEF     = 177,
    parameter int SHIFT    = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_t_vld,
    input  logic [15:0] i_t_us,
    output logic        o_busy,
    output logic        o_dist_vld,
    output logic [15:0] o_dist_mm,
    output logic [15:0] o_dist_raw,
    output logic        o_range_err
);

    localparam int           DEPTH     = 1 << AVG_LOG2;
    localparam logic [7:0]   COEF_BITS = 8'(COEF);
    localparam logic [15:0]  T_LO      = 16'(T_MIN);
    localparam logic [15:0]  T_HI      = 16'(T_MAX);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        AVG,
        OUT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [15:0]            t_reg;
    logic [23:0]            acc_reg;
    logic [2:0]             k_reg;
    logic [AVG_LOG2-1:0]    wr_ptr_reg;
    logic                   fill_reg;
    logic [DEPTH-1:0][15:0] ring_reg;
    logic [DEPTH-1:0][15:0] ring_next;
    logic [15:0]            dist_mm_reg;
    logic [15:0]            dist_raw_reg;
    logic                   range_err_reg;

    logic        in_range;
    logic [23:0] t_ext;
    logic [23:0] partial;
    logic [15:0] raw;
    logic [17:0] sum;
    logic [15:0] avg;

    assign in_range = (t_reg >= T_LO) && (t_reg <= T_HI);
    assign t_ext    = {8'd0, t_reg};
    // Partial product for multiplier bit k; zero when that coefficient bit is clear.
    assign partial  = COEF_BITS[k_reg] ? (t_ext << k_reg) : 24'd0;
    assign raw      = 16'(acc_reg >> SHIFT);

    // Until the ring is filled the first in-range sample preloads every entry,
    // so the average starts at that sample rather than ramping up from zero.
    // After that only the oldest entry, at the write pointer, is replaced.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_ring_next
        assign ring_next[gi] = (!fill_reg || (wr_ptr_reg == AVG_LOG2'(gi))) ? raw : ring_reg[gi];
    end

    // Sum of the ring contents as they will be after this write.
    always_comb begin
        sum = 18'd0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + 18'(ring_next[i]);
        end
    end

    assign avg = 16'(sum >> AVG_LOG2);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    // Strobes that arrive outside IDLE are simply not looked at, so they are dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_t_vld) state_next = CHECK;
            CHECK:   state_next = in_range ? MUL : OUT;
            MUL:     if (k_reg == 3'd7) state_next = AVG;
            AVG:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sample latch, shift-add multiply, ring update and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            t_reg         <= '0;
            acc_reg       <= '0;
            k_reg         <= '0;
            wr_ptr_reg    <= '0;
            fill_reg      <= 1'b0;
            ring_reg      <= '0;
            dist_mm_reg   <= '0;
            dist_raw_reg  <= '0;
            range_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_t_vld) t_reg <= i_t_us;
                end
                CHECK: begin
                    if (!in_range) begin
                        // Out-of-range samples only raise the error flag.
                        // The ring and the distance outputs keep their values.
                        range_err_reg <= 1'b1;
                    end else begin
                        acc_reg <= '0;
                        k_reg   <= '0;
                    end
                end
                MUL: begin
                    acc_reg <= acc_reg + partial;
                    k_reg   <= k_reg + 3'd1;
                end
                AVG: begin
                    ring_reg      <= ring_next;
                    fill_reg      <= 1'b1;
                    if (fill_reg) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    dist_raw_reg  <= raw;
                    dist_mm_reg   <= avg;
                    range_err_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy      = (state_reg != IDLE);
    assign o_dist_vld  = (state_reg == OUT);
    assign o_dist_mm   = dist_mm_reg;
    assign o_dist_raw  = dist_raw_reg;
    assign o_range_err = range_err_reg;

endmodule

// File: tb/tb_vlg_echo_dist.sv
// Directed testbench for vlg_echo_dist.
// Expected values are hand-computed from t*177>>10 and a 4-entry running average.
module tb_vlg_echo_dist;

    logic        clk;
    logic        rst;
    logic        t_vld;
    logic [15:0] t_us;
    logic        busy;
    logic        dist_vld;
    logic [15:0] dist_mm;
    logic [15:0] dist_raw;
    logic        range_err;

    int vectors = 0;
    int miscompares = 0;

    vlg_echo_dist dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_t_vld     (t_vld),
        .i_t_us      (t_us),
        .o_busy      (busy),
        .o_dist_vld  (dist_vld),
        .o_dist_mm   (dist_mm),
        .o_dist_raw  (dist_raw),
        .o_range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe one sample at a negedge (cycle N).
    // Then find the first negedge with o_dist_vld and check latency and outputs.
    task automatic run(input string tag, input int t, input int lat,
                       input int raw, input int mm, input int err);
        int seen;
        seen = -1;
        @(negedge clk);
        t_vld = 1'b1;
        t_us  = 16'(t);
        for (int i = 1; i <= 20 && seen < 0; i++) begin
            @(negedge clk);
            t_vld = 1'b0;
            if (i == 1) chk({tag, " busy"}, int'(busy), 1);
            if (dist_vld) seen = i;
        end
        chk({tag, " latency"}, seen, lat);
        chk({tag, " raw"}, int'(dist_raw), raw);
        chk({tag, " mm"}, int'(dist_mm), mm);
        chk({tag, " err"}, int'(range_err), err);
        @(negedge clk);
        chk({tag, " vld pulse"}, int'(dist_vld), 0);
        chk({tag, " busy end"}, int'(busy), 0);
        $display("sample %s t=%0d raw=%0d mm=%0d err=%0d lat=%0d", tag, t, dist_raw, dist_mm, range_err, seen);
    endtask

    initial begin
        int n_vld;
        int first_at;
        int second_at;
        rst   = 1'b1;
        t_vld = 1'b0;
        t_us  = '0;
        #12;
        chk("reset mm", int'(dist_mm), 0);
        chk("reset raw", int'(dist_raw), 0);
        chk("reset err", int'(range_err), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset vld", int'(dist_vld), 0);
        @(negedge clk);
        rst = 1'b0;

        // Preload, then convergence.
        run("t5780 preload", 5780, 11, 999, 999, 0);
        run("t2890 a", 2890, 11, 499, 874, 0);
        run("t2890 b", 2890, 11, 499, 749, 0);
        run("t2890 c", 2890, 11, 499, 624, 0);
        run("t2890 d", 2890, 11, 499, 499, 0);

        // Boundary values.
        run("t11", 11, 11, 1, 374, 0);
        run("t26011", 26011, 11, 4496, 1373, 0);
        run("t10", 10, 2, 4496, 1373, 1);
        run("t26012", 26012, 2, 4496, 1373, 1);
        run("t0", 0, 2, 4496, 1373, 1);

        // Overlapping strobes at N+3 and N+11 are dropped; the one at N+12 is taken.
        n_vld     = 0;
        first_at  = -1;
        second_at = -1;
        @(negedge clk);
        t_vld = 1'b1;
        t_us  = 16'd5780;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            t_vld = 1'b0;
            if (dist_vld) begin
                n_vld++;
                if (first_at < 0) first_at = i;
                else second_at = i;
                if (i == 11) begin
                    chk("overlap raw1", int'(dist_raw), 999);
                    chk("overlap mm1", int'(dist_mm), 1498);
                    chk("overlap err1", int'(range_err), 0);
                end
                if (i == 23) begin
                    chk("overlap raw2", int'(dist_raw), 199);
                    chk("overlap mm2", int'(dist_mm), 1423);
                end
            end
            if (i == 3)  begin t_vld = 1'b1; t_us = 16'd10;   end
            if (i == 11) begin t_vld = 1'b1; t_us = 16'd10;   end
            if (i == 12) begin t_vld = 1'b1; t_us = 16'd1157; end
        end
        chk("overlap vld count", n_vld, 2);
        chk("overlap first", first_at, 11);
        chk("overlap second", second_at, 23);
        $display("overlap vld_count=%0d first=%0d second=%0d", n_vld, first_at, second_at);

        // Asynchronous reset in the middle of MUL.
        @(negedge clk);
        t_vld = 1'b1;
        t_us  = 16'd2890;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            t_vld = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst mm", int'(dist_mm), 0);
        chk("midrst raw", int'(dist_raw), 0);
        chk("midrst err", int'(range_err), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst vld", int'(dist_vld), 0);
        @(negedge clk);
        rst   = 1'b0;
        n_vld = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (dist_vld) n_vld++;
        end
        chk("midrst no vld", n_vld, 0);
        $display("midrst mm=%0d raw=%0d vld_after=%0d", dist_mm, dist_raw, n_vld);
        run("t5780 after rst", 5780, 11, 999, 999, 0);

        // Ring wrap.
        run("wrap1", 1157, 11, 199, 799, 0);
        run("wrap2", 1157, 11, 199, 599, 0);
        run("wrap3", 1157, 11, 199, 399, 0);
        run("wrap4", 1157, 11, 199, 199, 0);
        run("wrap5", 1157, 11, 199, 199, 0);
        run("wrap6", 1157, 11, 199, 199, 0);
        run("wrap t5780", 5780, 11, 999, 399, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
